// File: rtl/mem_stage.sv
// Data-memory access stage: byte-addressed little-endian RAM with combinational
// loads, edge-triggered stores and a combinational access-fault flag.
module mem_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  mem_size,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        mem_exception
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    mem_d [MEM_BYTES];
  logic [3:0]    nbytes;
  logic [2:0]    align_mask;
  logic [64:0]   end_addr;
  logic [AW-1:0] base;
  logic          misaligned;
  logic          out_of_range;
  logic          reserved;
  logic          fault;

  always_comb begin
    nbytes     = 4'd1;
    align_mask = 3'd0;
    case (mem_size[1:0])
      2'b00: begin nbytes = 4'd1; align_mask = 3'd0; end
      2'b01: begin nbytes = 4'd2; align_mask = 3'd1; end
      2'b10: begin nbytes = 4'd4; align_mask = 3'd3; end
      default: begin nbytes = 4'd8; align_mask = 3'd7; end
    endcase
    // End address is computed one bit wider so huge addresses cannot wrap into range.
    end_addr     = {1'b0, address} + 65'(nbytes);
    misaligned   = (address[2:0] & align_mask) != 3'd0;
    out_of_range = end_addr > 65'(MEM_BYTES);
    reserved     = mem_size[2];
    fault        = (memread | memwrite) & (misaligned | out_of_range | reserved);
    base         = address[AW-1:0];
  end

  assign mem_exception = fault & ~rst;

  always_comb begin
    read_data = 64'd0;
    if (!rst && memread && !fault) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(nbytes)) read_data[8*i +: 8] = mem_q[base + AW'(i)];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (memwrite && !fault) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(nbytes)) mem_d[base + AW'(i)] = write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < MEM_BYTES; j++) mem_q[j] <= 8'd0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected load data and fault flag are queued
// as each request is driven and checked once the combinational outputs settle.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [2:0]  mem_size;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        mem_exception;

  typedef struct {
    logic [63:0] rd;
    logic        exc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  mem_stage #(.MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .memread      (memread),
    .memwrite     (memwrite),
    .mem_size     (mem_size),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .mem_exception(mem_exception)
  );

  always #5 clk = ~clk;

  task automatic check();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (read_data === e.rd) else begin
      failed++;
      $error("FAIL %s read_data: observed %h expected %h", e.tag, read_data, e.rd);
    end
    tests++;
    assert (mem_exception === e.exc) else begin
      failed++;
      $error("FAIL %s mem_exception: observed %b expected %b", e.tag, mem_exception, e.exc);
    end
  endtask

  // Drive one request after the falling edge, check the settled outputs, and
  // let the following rising edge commit any store.
  task automatic step(input logic r, input logic rd, input logic wr, input logic [2:0] sz,
                      input logic [63:0] addr, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_exc, input string tag);
    exp_t e;
    @(negedge clk);
    rst        = r;
    memread    = rd;
    memwrite   = wr;
    mem_size   = sz;
    address    = addr;
    write_data = wd;
    e.rd = exp_rd; e.exc = exp_exc; e.tag = tag;
    sb.push_back(e);
    #1;
    check();
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; mem_size = 3'd0;
    address = 64'd0; write_data = 64'd0;

    step(1, 1, 0, 3'd3, 64'd0,  64'd0, 64'd0, 1'b0, "reset_ld");
    step(1, 1, 0, 3'd2, 64'd5,  64'd0, 64'd0, 1'b0, "reset_misaligned");

    step(0, 0, 1, 3'd0, 64'd0, 64'hA5, 64'd0, 1'b0, "sb0");
    step(0, 1, 0, 3'd0, 64'd0, 64'd0, 64'h00000000000000A5, 1'b0, "lb0");

    step(0, 0, 1, 3'd1, 64'd2, 64'h1234, 64'd0, 1'b0, "sh2");
    step(0, 1, 0, 3'd1, 64'd2, 64'd0, 64'h1234, 1'b0, "lh2");
    step(0, 1, 0, 3'd0, 64'd2, 64'd0, 64'h34,   1'b0, "lb2");
    step(0, 1, 0, 3'd0, 64'd3, 64'd0, 64'h12,   1'b0, "lb3");

    step(0, 0, 1, 3'd2, 64'd4, 64'hDEADBEEF, 64'd0, 1'b0, "sw4");
    step(0, 1, 0, 3'd2, 64'd4, 64'd0, 64'h00000000DEADBEEF, 1'b0, "lw4");
    step(0, 1, 0, 3'd2, 64'd5, 64'd0, 64'd0, 1'b1, "lw5_misaligned");
    step(0, 1, 0, 3'd3, 64'd0, 64'd0, 64'hDEADBEEF123400A5, 1'b0, "ld0_mixed");

    step(0, 0, 1, 3'd3, 64'd8,  64'h0123456789ABCDEF, 64'd0, 1'b0, "sd8");
    step(0, 1, 0, 3'd3, 64'd8,  64'd0, 64'h0123456789ABCDEF, 1'b0, "ld8");
    step(0, 0, 1, 3'd2, 64'd10, 64'hFFFFFFFF, 64'd0, 1'b1, "sw10_misaligned");
    step(0, 1, 0, 3'd3, 64'd8,  64'd0, 64'h0123456789ABCDEF, 1'b0, "ld8_unchanged");

    step(0, 1, 0, 3'd2, 64'd1020, 64'd0, 64'd0, 1'b0, "lw_top");
    step(0, 1, 0, 3'd2, 64'd1024, 64'd0, 64'd0, 1'b1, "lw_oor");
    step(0, 1, 0, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1'b1, "ld_wrap");
    step(0, 0, 1, 3'd3, 64'd1016, 64'h1122334455667788, 64'd0, 1'b0, "sd_last");
    step(0, 1, 0, 3'd3, 64'd1016, 64'd0, 64'h1122334455667788, 1'b0, "ld_last");
    step(0, 0, 1, 3'd3, 64'd1020, 64'hFFFF, 64'd0, 1'b1, "sd_oor");
    step(0, 1, 0, 3'd3, 64'd1016, 64'd0, 64'h1122334455667788, 1'b0, "ld_last_kept");

    step(0, 1, 1, 3'd0, 64'd0, 64'h5A, 64'hA5, 1'b0, "rw_same_pre");
    step(0, 1, 0, 3'd0, 64'd0, 64'd0, 64'h5A, 1'b0, "rw_same_post");

    step(1, 0, 1, 3'd0, 64'd16, 64'h77, 64'd0, 1'b0, "rst_blocks_store");
    step(0, 1, 0, 3'd0, 64'd0,  64'd0, 64'd0, 1'b0, "lb0_after_rst");
    step(0, 1, 0, 3'd0, 64'd16, 64'd0, 64'd0, 1'b0, "lb16_after_rst");
    step(0, 1, 0, 3'd3, 64'd8,  64'd0, 64'd0, 1'b0, "ld8_after_rst");

    step(0, 1, 0, 3'd4, 64'd0, 64'd0, 64'd0, 1'b1, "reserved_rd");
    step(0, 0, 1, 3'd7, 64'd0, 64'hFF, 64'd0, 1'b1, "reserved_wr");
    step(0, 1, 0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, "lb0_after_reserved_wr");
    step(0, 0, 0, 3'd2, 64'd5, 64'd0, 64'd0, 1'b0, "idle");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
